divider_reconstruct_seq: RTL and testbench

//   Inverse of the 2W/W array divider: rebuilds dividend n_rec = q*d + r from a

---
 rtl/divider_pkg.sv | 18 +
 rtl/divider_shift_add_step.sv | 21 ++
 rtl/divider_reconstruct_seq.sv | 134 +++++++++++++
 tb/tb_divider_reconstruct_seq.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared types and defaults for the sequential dividend reconstructor.
// Optional error metrics are enabled with DIVIDER_ERR_METRIC_EN.
package divider_pkg;

  localparam int DIV_W     = 8;
  localparam int DIV_ACC_W = 40;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_bits(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/divider_shift_add_step.sv
// One radix-2 shift-add step: adds d<<cnt into the accumulator
// when the selected multiplier bit is set.
module divider_shift_add_step
  import divider_pkg::*;
#(
  parameter int W  = DIV_W,
  parameter int CW = cnt_bits(W)
) (
  input  logic [2*W-1:0] acc,
  input  logic [W-1:0]   d,
  input  logic           q_bit,
  input  logic [CW-1:0]  cnt,
  output logic [2*W-1:0] acc_next
);

  logic [2*W-1:0] addend;

  assign addend   = {{W{1'b0}}, d} << cnt;
  assign acc_next = q_bit ? (acc + addend) : acc;

endmodule

// File: rtl/divider_reconstruct_seq.sv
// Rebuilds n_rec = q*d + r over W shift-add cycles, valid/ready both sides.
// DIVIDER_ERR_METRIC_EN adds |n_ref - n_rec| and a saturating squared-error sum.
module divider_reconstruct_seq
  import divider_pkg::*;
#(
  parameter int W     = DIV_W,
  parameter int ACC_W = DIV_ACC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     q,
  input  logic [W-1:0]     d,
  input  logic [W-1:0]     r,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef DIVIDER_ERR_METRIC_EN
  input  logic [2*W-1:0]   n_ref,
  input  logic             clr_metric,
  output logic [2*W-1:0]   err_abs,
  output logic [ACC_W-1:0] err_sq_acc,
  output logic [31:0]      sample_cnt,
`endif
  output logic [2*W-1:0]   n_rec
);

  localparam int CW = cnt_bits(W);

  state_t         state_q;
  state_t         state_d;
  logic [W-1:0]   q_reg;
  logic [W-1:0]   d_reg;
  logic [2*W-1:0] acc;
  logic [2*W-1:0] acc_next;
  logic [CW-1:0]  cnt;
  logic           accept;
  logic           last_step;

  assign accept    = in_valid && in_ready;
  assign last_step = (cnt == CW'(W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid)  state_d = BUSY;
      BUSY: if (last_step) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default:             state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  divider_shift_add_step #(
    .W  (W),
    .CW (CW)
  ) u_step (
    .acc      (acc),
    .d        (d_reg),
    .q_bit    (q_reg[cnt]),
    .cnt      (cnt),
    .acc_next (acc_next)
  );

  // Remainder seeds the accumulator so no extra add is needed at the end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg <= '0;
      d_reg <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else if (accept) begin
      q_reg <= q;
      d_reg <= d;
      acc   <= {{W{1'b0}}, r};
      cnt   <= '0;
    end else if (state_q == BUSY) begin
      acc   <= acc_next;
      cnt   <= cnt + 1'b1;
    end
  end

  assign n_rec = acc;

`ifdef DIVIDER_ERR_METRIC_EN
  localparam int SQ_W  = 4 * W;
  localparam int SUM_W = ((ACC_W > SQ_W) ? ACC_W : SQ_W) + 1;

  logic [2*W-1:0]   n_ref_reg;
  logic [SQ_W-1:0]  err_sq;
  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] acc_max;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_ref_reg <= '0;
    end else if (accept) begin
      n_ref_reg <= n_ref;
    end
  end

  assign err_abs = (n_ref_reg >= acc) ? (n_ref_reg - acc)
                                      : (acc - n_ref_reg);
  assign err_sq  = SQ_W'(err_abs) * SQ_W'(err_abs);
  assign sum     = SUM_W'(err_sq_acc) + SUM_W'(err_sq);
  assign acc_max = SUM_W'({ACC_W{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sq_acc <= '0;
      sample_cnt <= '0;
    end else if (clr_metric) begin
      err_sq_acc <= '0;
      sample_cnt <= '0;
    end else if (out_valid && out_ready) begin
      err_sq_acc <= (sum > acc_max) ? '1 : sum[ACC_W-1:0];
      sample_cnt <= sample_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_divider_reconstruct_seq.sv
// Directed and random bench for divider_reconstruct_seq with a q*d+r
// scoreboard; metric checks follow DIVIDER_ERR_METRIC_EN.
module tb_divider_reconstruct_seq;

  localparam int W     = 8;
  localparam int ACC_W = 40;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     q;
  logic [W-1:0]     d;
  logic [W-1:0]     r;
  logic             out_valid;
  logic             out_ready;
  logic [2*W-1:0]   n_rec;
  logic [2*W-1:0]   n_ref;
  logic             clr_metric;
`ifdef DIVIDER_ERR_METRIC_EN
  logic [2*W-1:0]   err_abs;
  logic [ACC_W-1:0] err_sq_acc;
  logic [31:0]      sample_cnt;
`endif

  always #5 clk = ~clk;

  divider_reconstruct_seq #(
    .W     (W),
    .ACC_W (ACC_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .q          (q),
    .d          (d),
    .r          (r),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
`ifdef DIVIDER_ERR_METRIC_EN
    .n_ref      (n_ref),
    .clr_metric (clr_metric),
    .err_abs    (err_abs),
    .err_sq_acc (err_sq_acc),
    .sample_cnt (sample_cnt),
`endif
    .n_rec      (n_rec)
  );

  logic [2*W-1:0]   sb[$];
  logic [2*W-1:0]   errq[$];
  logic [ACC_W-1:0] m_sq;
  int               m_cnt;
  int               tests;
  int               fails;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [W-1:0] qi, input logic [W-1:0] di,
                          input logic [W-1:0] ri, input logic [2*W-1:0] nr);
    logic [2*W-1:0] e;
    e = (2*W)'(qi) * (2*W)'(di) + (2*W)'(ri);
    sb.push_back(e);
    errq.push_back((nr >= e) ? (nr - e) : (e - nr));
  endtask

  task automatic send(input logic [W-1:0] qi, input logic [W-1:0] di,
                      input logic [W-1:0] ri, input logic [2*W-1:0] nr);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin
      tick;
      n++;
    end
    if (!in_ready) check("send_timeout", 64'(in_ready), 64'd1);
    q = qi; d = di; r = ri; n_ref = nr;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    push_exp(qi, di, ri, nr);
  endtask

  task automatic recv(input string tag, input int gap);
    int n;
    logic [2*W-1:0] e;
    logic [2*W-1:0] ee;
    n = 0;
    while (!out_valid && n < 200) begin
      tick;
      n++;
    end
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    repeat (gap) tick;
    e  = (sb.size() > 0) ? sb.pop_front() : '1;
    ee = (errq.size() > 0) ? errq.pop_front() : '1;
    check(tag, 64'(n_rec), 64'(e));
`ifdef DIVIDER_ERR_METRIC_EN
    check({tag, "_err"}, 64'(err_abs), 64'(ee));
`endif
    m_sq  = m_sq + ACC_W'(ee) * ACC_W'(ee);
    m_cnt = m_cnt + 1;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    tests = 0; fails = 0; m_sq = '0; m_cnt = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    q = '0; d = '0; r = '0; n_ref = '0; clr_metric = 1'b0;
    #12;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_n_rec", 64'(n_rec), 64'd0);
`ifdef DIVIDER_ERR_METRIC_EN
    check("rst_sq_acc", 64'(err_sq_acc), 64'd0);
    check("rst_samples", 64'(sample_cnt), 64'd0);
`endif
    tick;
    rst_n = 1'b1;
    tick;

    // latency from the accept edge (counted as cycle 1) to out_valid
    q = 8'h2A; d = 8'h05; r = 8'h03; n_ref = 16'h00D7;
    push_exp(8'h2A, 8'h05, 8'h03, 16'h00D7);
    in_valid = 1'b1;
    lat = 0;
    do begin
      tick;
      in_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 50);
    check("latency", 64'(lat), 64'(W + 1));
    recv("op_2a_05_03", 0);
`ifdef DIVIDER_ERR_METRIC_EN
    check("metric_sq1", 64'(err_sq_acc), 64'd4);
    check("metric_cnt1", 64'(sample_cnt), 64'd1);
`endif
    send(8'h2A, 8'h05, 8'h03, 16'h00D2);
    recv("op_err3", 1);
`ifdef DIVIDER_ERR_METRIC_EN
    check("metric_sq2", 64'(err_sq_acc), 64'd13);
    check("metric_cnt2", 64'(sample_cnt), 64'd2);
`endif
    clr_metric = 1'b1;
    tick;
    clr_metric = 1'b0;
    m_sq = '0; m_cnt = 0;
`ifdef DIVIDER_ERR_METRIC_EN
    check("metric_clr_sq", 64'(err_sq_acc), 64'd0);
    check("metric_clr_cnt", 64'(sample_cnt), 64'd0);
`endif

    // stall in DONE while offering a new operand set
    send(8'hFF, 8'hFF, 8'hFF, 16'h0000);
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick;
      lat++;
    end
    for (int i = 0; i < 5; i++) begin
      q = 8'h01; d = 8'h01; r = 8'h01;
      in_valid = 1'b1;
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_ready", 64'(in_ready), 64'd0);
      check("stall_n_rec", 64'(n_rec), 64'hFF00);
      tick;
    end
    in_valid = 1'b0;
    recv("op_ff_ff_ff", 0);
    check("post_done_ready", 64'(in_ready), 64'd1);
    check("post_done_valid", 64'(out_valid), 64'd0);
    tick;
    check("ignored_in_valid", 64'(in_ready), 64'd1);

    send(8'h00, 8'h00, 8'h7F, 16'h007F);
    recv("op_zero_zero", 0);
    send(8'h00, 8'h9C, 8'h11, 16'h0011);
    recv("op_q_zero", 2);
    send(8'hC3, 8'h00, 8'h22, 16'h0022);
    recv("op_d_zero", 0);
    send(8'h10, 8'h05, 8'hF0, 16'h0140);
    recv("op_r_ge_d", 1);

    // asynchronous reset in the middle of BUSY drops the operation
    send(8'h2A, 8'h05, 8'h03, 16'h00D5);
    tick; tick; tick;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_ready", 64'(in_ready), 64'd1);
    check("midrst_n_rec", 64'(n_rec), 64'd0);
    void'(sb.pop_back());
    void'(errq.pop_back());
    m_sq = '0; m_cnt = 0;
    tick;
    rst_n = 1'b1;
    tick;
    send(8'h03, 8'h07, 8'h01, 16'h0016);
    recv("op_after_rst", 0);
    check("op_after_rst_lit", 64'(n_rec), 64'h0016);

    for (int i = 0; i < 1500; i++) begin
      repeat ($urandom_range(0, 2)) tick;
      send(W'($urandom), W'($urandom), W'($urandom),
           (2*W)'($urandom_range(0, 65535)));
      recv("rand_n_rec", $urandom_range(0, 3));
    end
`ifdef DIVIDER_ERR_METRIC_EN
    check("rand_sq_acc", 64'(err_sq_acc), 64'(m_sq));
    check("rand_samples", 64'(sample_cnt), 64'(m_cnt));
`endif
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
